// File: rtl/spi_frame_ctrl_if.sv
// Shift-register strobe and one-deep valid/ready frame output of spi_frame_ctrl.
// Master side drives the strobes and the frame; slave side returns the parallel word and ready.
interface spi_frame_ctrl_if #(
  parameter int WL = 96
);
  logic          s2p_en;
  logic          s2p_in;
  logic [WL-1:0] s2p_data;
  logic [WL-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  modport master (
    output s2p_en,
    output s2p_in,
    output out_data,
    output out_valid,
    input  s2p_data,
    input  out_ready
  );

  modport slave (
    input  s2p_en,
    input  s2p_in,
    input  out_data,
    input  out_valid,
    output s2p_data,
    output out_ready
  );
endinterface

// File: rtl/spi_frame_ctrl.sv
// SPI mode-0 slave framer: sync + registered edge detect, shift strobes at SYNC+2 clk, frame out at SYNC+3 clk.
// One-deep output register; a good frame arriving while it is held and not being drained is dropped (overflow).
module spi_frame_ctrl #(
  parameter int WL   = 96,
  parameter int SYNC = 2
) (
  input  logic              clk,
  input  logic              iRST,
  input  logic              iSCLK,
  input  logic              iCS_n,
  input  logic              iMOSI,
  spi_frame_ctrl_if.master  bus,
  output logic              frame_err,
  output logic              overflow,
  output logic              busy
);

  localparam int CW     = $clog2(WL + 1) + 1;
  localparam int SETTLE = SYNC + 1;
  localparam int SW     = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_HOLD,
    S_CAPTURE
  } state_t;

  logic [SYNC-1:0] sclk_sync_q;
  logic [SYNC-1:0] cs_sync_q;
  logic [SYNC-1:0] mosi_sync_q;
  logic            sclk_dly_q;
  logic            cs_dly_q;
  logic            mosi_dly_q;
  logic            sclk_rise_q, sclk_rise_d;
  logic            cs_fall_q, cs_fall_d;
  logic            cs_rise_q, cs_rise_d;
  logic [SW-1:0]   settle_q;
  logic            settled;

  state_t          state_q, state_d;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic            s2p_en_q, s2p_en_d;
  logic            s2p_in_q, s2p_in_d;
  logic [WL-1:0]   out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            overflow_q, overflow_d;

  // Edges are masked until the chains have flushed their reset values, so a CS_n
  // already low at reset release never looks like a falling edge.
  assign settled     = (settle_q == SW'(SETTLE));
  assign sclk_rise_d = settled &  sclk_sync_q[SYNC-1] & ~sclk_dly_q;
  assign cs_fall_d   = settled & ~cs_sync_q[SYNC-1]   &  cs_dly_q;
  assign cs_rise_d   = settled &  cs_sync_q[SYNC-1]   & ~cs_dly_q;

  always_ff @(posedge clk) begin
    if (iRST) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_dly_q  <= 1'b0;
      cs_dly_q    <= 1'b1;
      mosi_dly_q  <= 1'b0;
      sclk_rise_q <= 1'b0;
      cs_fall_q   <= 1'b0;
      cs_rise_q   <= 1'b0;
      settle_q    <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC-2:0], iSCLK};
      cs_sync_q   <= {cs_sync_q[SYNC-2:0], iCS_n};
      mosi_sync_q <= {mosi_sync_q[SYNC-2:0], iMOSI};
      sclk_dly_q  <= sclk_sync_q[SYNC-1];
      cs_dly_q    <= cs_sync_q[SYNC-1];
      mosi_dly_q  <= mosi_sync_q[SYNC-1];
      sclk_rise_q <= sclk_rise_d;
      cs_fall_q   <= cs_fall_d;
      cs_rise_q   <= cs_rise_d;
      if (!settled) begin
        settle_q <= settle_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (iRST) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      s2p_en_q    <= 1'b0;
      s2p_in_q    <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      s2p_en_q    <= s2p_en_d;
      s2p_in_q    <= s2p_in_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    s2p_en_d    = 1'b0;
    s2p_in_d    = s2p_in_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q & ~bus.out_ready;
    frame_err_d = 1'b0;
    overflow_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cs_fall_q) begin
          state_d   = S_SHIFT;
          bit_cnt_d = '0;
        end
      end
      S_SHIFT: begin
        if (cs_rise_q) begin
          state_d     = S_IDLE;
          frame_err_d = 1'b1;
        end else if (sclk_rise_q) begin
          s2p_en_d  = 1'b1;
          s2p_in_d  = mosi_dly_q;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == CW'(WL - 1)) begin
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        // Extra clocks only count, so the shift register keeps the first WL bits.
        if (cs_rise_q) begin
          if (bit_cnt_q == CW'(WL)) begin
            state_d = S_CAPTURE;
          end else begin
            state_d     = S_IDLE;
            frame_err_d = 1'b1;
          end
        end else if (sclk_rise_q && (bit_cnt_q != CW'(WL + 1))) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      S_CAPTURE: begin
        state_d = S_IDLE;
        if (!out_valid_q || bus.out_ready) begin
          out_data_d  = bus.s2p_data;
          out_valid_d = 1'b1;
        end else begin
          overflow_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.s2p_en    = s2p_en_q;
  assign bus.s2p_in    = s2p_in_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign frame_err     = frame_err_q;
  assign overflow      = overflow_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Bench for spi_frame_ctrl: behavioural shift register, pin-level SPI driver, and
// a frame-level reference (pulse counts, error/capture outcome) per directed or random frame.
module tb_spi_frame_ctrl;
  localparam int WL   = 96;
  localparam int SYNC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic iRST, iSCLK, iCS_n, iMOSI;
  logic frame_err, overflow, busy;

  spi_frame_ctrl_if #(.WL(WL)) bus ();

  spi_frame_ctrl #(.WL(WL), .SYNC(SYNC)) dut (
    .clk       (clk),
    .iRST      (iRST),
    .iSCLK     (iSCLK),
    .iCS_n     (iCS_n),
    .iMOSI     (iMOSI),
    .bus       (bus),
    .frame_err (frame_err),
    .overflow  (overflow),
    .busy      (busy)
  );

  logic [WL-1:0] sr = '0;
  always @(posedge clk) if (bus.s2p_en) sr <= {sr[WL-2:0], bus.s2p_in};
  assign bus.s2p_data = sr;

  int en_cnt, err_cnt, ovf_cnt, vlow_cnt, vhi_cnt;
  logic [WL-1:0] got[$];
  always @(negedge clk) begin
    if (!iRST) begin
      if (bus.s2p_en) en_cnt++;
      if (frame_err) err_cnt++;
      if (overflow) ovf_cnt++;
      if (bus.out_valid) vhi_cnt++; else vlow_cnt++;
      if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
    end
  end

  int n_checks = 0;
  int n_pass   = 0;
  int rd       = 0;

  task automatic chk(input string tag, input logic [WL-1:0] obs, input logic [WL-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [WL-1:0] rnd_word();
    return {$urandom, $urandom, $urandom};
  endfunction

  task automatic send_bits(input int n, input logic [WL-1:0] d, input int h);
    for (int i = 0; i < n; i++) begin
      iSCLK = 1'b0;
      if (i < WL) iMOSI = d[WL-1-i];
      else        iMOSI = 1'($urandom);
      tick(h);
      iSCLK = 1'b1;
      tick(h);
    end
    iSCLK = 1'b0;
  endtask

  // Returns clocks from CS_n rising to the out_valid rising edge, -1 if none;
  // with acc set, out_ready is pulsed for exactly the capture cycle.
  task automatic frame(input int n, input logic [WL-1:0] d, input int h, input bit acc, output int lat);
    logic pv;
    iCS_n = 1'b0;
    tick(h);
    send_bits(n, d, h);
    tick(h);
    iCS_n = 1'b1;
    lat = -1;
    pv = bus.out_valid;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      if (lat < 0 && bus.out_valid && !pv) lat = k;
      pv = bus.out_valid;
      if (acc && k == SYNC + 2) bus.out_ready = 1'b1;
      if (acc && k == SYNC + 3) bus.out_ready = 1'b0;
    end
  endtask

  // Reference outcome with out_ready held high: min(n,WL) strobes, error unless n==WL,
  // exactly one handshake carrying the frame's first WL bits when n==WL.
  task automatic model_frame(input string tag, input int n, input logic [WL-1:0] d, input int h, output int lat);
    int e0, r0, o0, g0;
    e0 = en_cnt; r0 = err_cnt; o0 = ovf_cnt; g0 = got.size();
    frame(n, d, h, 1'b0, lat);
    chk({tag, "_en"},  WL'(en_cnt - e0),  WL'((n < WL) ? n : WL));
    chk({tag, "_err"}, WL'(err_cnt - r0), WL'((n != WL) ? 1 : 0));
    chk({tag, "_ovf"}, WL'(ovf_cnt - o0), '0);
    chk({tag, "_cap"}, WL'(got.size() - g0), WL'((n == WL) ? 1 : 0));
    if (n == WL && got.size() > rd) begin
      chk({tag, "_data"}, got[rd], d);
      rd++;
    end
    rd = got.size();
  endtask

  initial begin
    logic [WL-1:0] f1, f2, f3;
    int lat, v0, o0, g0, e0, r0, n, h;

    iRST = 1'b1; iSCLK = 1'b0; iCS_n = 1'b1; iMOSI = 1'b0;
    bus.out_ready = 1'b0;
    tick(3);
    chk("rst_s2p_en",    WL'(bus.s2p_en),    '0);
    chk("rst_s2p_in",    WL'(bus.s2p_in),    '0);
    chk("rst_out_data",  bus.out_data,       '0);
    chk("rst_out_valid", WL'(bus.out_valid), '0);
    chk("rst_frame_err", WL'(frame_err),     '0);
    chk("rst_overflow",  WL'(overflow),      '0);
    chk("rst_busy",      WL'(busy),          '0);
    iRST = 1'b0;
    tick(6);

    bus.out_ready = 1'b1;
    v0 = vhi_cnt;
    f1 = {12{8'hA5}};
    model_frame("a5", WL, f1, 4, lat);
    chk("a5_valid_cycles", WL'(vhi_cnt - v0), WL'(1));
    chk("a5_latency", WL'(lat), WL'(SYNC + 3));
    chk("a5_idle", WL'(busy), '0);

    model_frame("short40", 40, rnd_word(), 4, lat);
    chk("short40_valid", WL'(bus.out_valid), '0);
    model_frame("after_short", WL, rnd_word(), 4, lat);
    model_frame("long100", 100, rnd_word(), 4, lat);
    chk("long100_valid", WL'(bus.out_valid), '0);

    // Output register full: hold first, drop second, replace in the accept cycle.
    bus.out_ready = 1'b0;
    f1 = {4'h1, rnd_word()} & {4'hF, {(WL-4){1'b1}}};
    f2 = {4'h2, f1[WL-5:0] ^ {(WL-4){1'b1}}};
    f3 = {4'h3, rnd_word()} & {4'hF, {(WL-4){1'b1}}};
    o0 = ovf_cnt; g0 = got.size();
    frame(WL, f1, 4, 1'b0, lat);
    chk("hold1_valid", WL'(bus.out_valid), WL'(1));
    chk("hold1_data", bus.out_data, f1);
    frame(WL, f2, 4, 1'b0, lat);
    chk("drop2_ovf", WL'(ovf_cnt - o0), WL'(1));
    chk("drop2_data", bus.out_data, f1);
    v0 = vlow_cnt;
    frame(WL, f3, 4, 1'b1, lat);
    chk("acc3_pops", WL'(got.size() - g0), WL'(1));
    if (got.size() > g0) chk("acc3_popped", got[g0], f1);
    chk("acc3_data", bus.out_data, f3);
    chk("acc3_valid", WL'(bus.out_valid), WL'(1));
    chk("acc3_no_gap", WL'(vlow_cnt - v0), '0);
    chk("acc3_ovf", WL'(ovf_cnt - o0), WL'(1));
    bus.out_ready = 1'b1;
    tick(2);
    chk("drain3_data", (got.size() > g0 + 1) ? got[g0+1] : '0, f3);
    chk("drain3_valid", WL'(bus.out_valid), '0);
    rd = got.size();

    // Reset in the middle of a frame with CS_n held low.
    iCS_n = 1'b0;
    tick(4);
    send_bits(50, rnd_word(), 4);
    iRST = 1'b1;
    tick(1);
    iRST = 1'b0;
    e0 = en_cnt; r0 = err_cnt; g0 = got.size();
    send_bits(30, rnd_word(), 4);
    tick(4);
    iCS_n = 1'b1;
    tick(12);
    chk("rstmid_en", WL'(en_cnt - e0), '0);
    chk("rstmid_err", WL'(err_cnt - r0), '0);
    chk("rstmid_cap", WL'(got.size() - g0), '0);
    chk("rstmid_valid", WL'(bus.out_valid), '0);
    model_frame("post_rst", WL, rnd_word(), 4, lat);

    model_frame("minper", WL, rnd_word(), SYNC + 1, lat);

    for (int i = 0; i < 6; i++) begin
      n = ($urandom_range(0, 1) == 1) ? WL : int'($urandom_range(1, 110));
      h = int'($urandom_range(SYNC + 1, SYNC + 3));
      model_frame($sformatf("rnd%0d", i), n, rnd_word(), h, lat);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/spi_frame_ctrl.md
# spi_frame_ctrl

SPI-slave frame controller that sequences the 96-bit serial-to-parallel shift register. It synchronizes the asynchronous SPI pins (SCLK, CS_n, MOSI) into the system clock domain and produces one-cycle shift enables with aligned serial data. It counts bits per chip-select frame, validates frame length, and delivers each complete word through a one-deep valid/ready output register. It sits between the SPI pads and the downstream command decoder.

## Interface
- WL, 96, frame length in bits; must match the shift register length
- SYNC, 2, synchronizer depth for SCLK/CS_n/MOSI (≥2)
- clk  in  1  system clock; all logic on posedge
- iRST  in  1  reset, synchronous, active-high (one clock; reset is synchronous and active-high)
- iSCLK  in  1  SPI clock pin, async, mode 0 (sample on rising edge)
- iCS_n  in  1  SPI chip select pin, async, active-low
- iMOSI  in  1  SPI data pin, async
- s2p_en  out  1  shift enable to shift register
- s2p_in  out  1  serial bit to shift register, valid when s2p_en=1
- s2p_data  in  WL  parallel word from shift register
- out_data  out  WL  captured frame
- out_valid  out  1  out_data holds an unconsumed frame
- out_ready  in  1  consumer accepts out_data when out_valid&out_ready
- frame_err  out  1  one-cycle pulse: frame ended with bit count ≠ WL
- overflow  out  1  one-cycle pulse: good frame dropped because output register full
- busy  out  1  FSM not in IDLE

## Operation
- Pins pass through SYNC-flop synchronizers, then one delay flop per SCLK/CS_n for edge detection; MOSI gets the same total delay so it aligns with the SCLK edge.
- SCLK rise = sync_sclk & ~sclk_d; CS fall / CS rise likewise on synchronized CS_n.
- bit_cnt: width clog2(WL+1)+1, saturates at WL+1, cleared on entry to SHIFT.
- FSM states:
  - IDLE: s2p_en=0. On CS fall -> SHIFT. A CS_n level already low does not start a frame; a falling edge is required.
  - SHIFT: each SCLK rise -> s2p_en=1 for one cycle, s2p_in=aligned MOSI, bit_cnt+1. When bit_cnt reaches WL -> HOLD. On CS rise before that -> IDLE with frame_err pulse.
  - HOLD: further SCLK rises do not assert s2p_en, so the shift register keeps the good word. They increment bit_cnt (saturating). On CS rise -> CAPTURE if bit_cnt==WL, else IDLE with frame_err pulse.
  - CAPTURE: one cycle. If out_valid=0, or out_valid&out_ready in this cycle: out_data<=s2p_data and out_valid<=1. Otherwise the frame is dropped, overflow pulses and out_data is unchanged. -> IDLE.
- Output handshake: out_valid clears on out_valid&out_ready, except in the CAPTURE-accept case, where it stays 1 with new data.
- A CS fall and a CS rise in the same cycle cannot occur (single edge detector); a CS fall while in HOLD/SHIFT is impossible by construction.
- The shift register is never cleared between frames; a full WL-bit frame overwrites every bit.

## Timing
- Reset values: s2p_en=0, s2p_in=0, out_data=0, out_valid=0, frame_err=0, overflow=0, busy=0, FSM=IDLE, bit_cnt=0. Synchronizer flops reset to SCLK=0, CS_n=1, MOSI=0.
- s2p_en/s2p_in are registered. s2p_en is high in the cycle after clk edge SYNC+2 following the first clk edge that samples iSCLK high (latency SYNC+2 clk).
- Pin constraints: SCLK high and low ≥ SYNC+1 clk periods; CS_n high ≥ SYNC+2 clk between frames; MOSI stable across the sampling edge.
- Frame end: out_valid rises SYNC+3 clk after the first clk edge sampling iCS_n high (detect, HOLD->CAPTURE, register).
- frame_err and overflow: exactly one cycle each, registered.
- iRST mid-frame: immediate return to IDLE, no pulse, out_valid=0. A frame still in progress when reset releases is ignored until CS_n goes high and then falls again.

## Test plan
- Reset, then one 96-bit frame of 0xA5A5…A5 (MSB first), out_ready=1 -> exactly 96 s2p_en pulses; out_valid=1 for 1 cycle with out_data=0xA5…A5; no error pulses.
- Short frame of 40 bits, then CS_n high -> frame_err single pulse, out_valid stays 0; the next 96-bit frame is captured correctly.
- Long frame of 100 bits -> s2p_en pulses exactly 96 times, frame_err pulses at CS rise, out_valid stays 0.
- out_ready=0, two back-to-back good frames (0x1…, 0x2…) -> first held in out_data, overflow pulses on the second. Then ready with a third frame arriving in the accept cycle -> out_data=third and out_valid stays 1.
- iRST asserted after 50 bits with CS_n held low, then 30 more SCLKs before CS_n rises -> no s2p_en after reset, no capture, no frame_err. The next full frame is captured.
- SCLK at the minimum legal period (SYNC+1 high/low) -> all 96 bits shifted, data correct.
